lte_up_dfe_antsw_cfg_sched: RTL and testbench
=============================================

LTE_UP_DFE_ANTSW_CFG_SCHED -- requirements
Module: lte_up_dfe_antsw_cfg_sched

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4915200: expected frame-head period in clock cycles (10 ms).
REQ-002 SHALL have parameter FRAME_TOL, default 2: allowed ± cycle deviation of the period.
REQ-003 SHALL have parameter LOCK_CNT, default 3: consecutive in-tolerance periods required for lock.
REQ-004 SHALL have the following ports:
- sys_clk_491p52  in  1  sole clock.
- sys_rst_491p52  in  1  reset, synchronous, active-low.
- i_cfg_vld  in  1  new configuration offered.
- i_cfg_ant_pos  in  32  eight 4-bit antenna slot fields.
- i_cfg_mod_sel  in  2  0=5M, 1=10M, 2=15M, 3=20M.
- o_cfg_rdy  out  1  configuration accepted when i_cfg_vld and o_cfg_rdy are both high.
- i_fram  in  1  frame strobe.
- i_xant  in  1  antenna strobe; frame head = i_fram & i_xant.
- o_ant_pos  out  32  committed antenna map to the antenna-switch datapath.
- o_mod_sel  out  2  committed bandwidth mode.
- o_commit  out  1  one-cycle pulse: new configuration applied.
- o_cfg_err  out  1  one-cycle pulse: configuration rejected.
- o_lock  out  1  frame timing locked.
- o_lock_lost  out  1  one-cycle pulse on LOCK exit.

Function
REQ-005 Config check SHALL run on the accepted beat, with the result registered one cycle later. Valid means:
- bit 3 of every nibble is 0;
- the eight 3-bit fields form a permutation of 0..7.
REQ-006 Config FSM states SHALL be IDLE, CHECK, PEND and APPLY. o_cfg_rdy SHALL be high only in IDLE.
REQ-007 Config FSM transitions:
- IDLE→CHECK on accept; the shadow registers capture the inputs.
- CHECK→PEND if valid; CHECK→IDLE with an o_cfg_err pulse if invalid.
REQ-008 PEND→APPLY SHALL occur on the frame-head cycle when commit is permitted (REQ-015). At that same clock edge o_ant_pos and o_mod_sel SHALL take the shadow values. o_commit SHALL be high during APPLY. APPLY→IDLE SHALL follow unconditionally.
REQ-009 o_ant_pos and o_mod_sel SHALL change only on an APPLY entry edge. Between commits they SHALL be stable.
REQ-010 Period counter, 23 bits:
- cleared to 0 on each frame head, otherwise incremented;
- saturates at FRAME_LEN+FRAME_TOL.
- The measured period at a head is counter+1.
REQ-011 Lock FSM states SHALL be UNLOCK, SEARCH and LOCK.
- UNLOCK→SEARCH on any head, good count = 0.
- SEARCH: an in-tolerance head increments the good count; when it reaches LOCK_CNT the FSM goes to LOCK. An out-of-tolerance head clears the good count.
REQ-012 In SEARCH or LOCK, if the counter reaches FRAME_LEN+FRAME_TOL without a head, the FSM SHALL go to UNLOCK.
REQ-013 In LOCK, an out-of-tolerance head or a missing head SHALL take the FSM to UNLOCK with a one-cycle o_lock_lost pulse. o_lock SHALL equal (state==LOCK).
REQ-014 A head arriving in the same cycle as the lock transition SHALL be judged using the lock state before that transition.
REQ-015 Commit permission SHALL be as defined under Configuration. A PEND configuration SHALL persist across lock loss and commit at the first permitted head.

Reset
REQ-016 When sys_rst_491p52 is low at a clock edge, the block SHALL reset to:
- config FSM IDLE, lock FSM UNLOCK, counter 0;
- o_ant_pos=32'h76543210, o_mod_sel=2'd3;
- o_cfg_rdy=0 during reset, 1 on the first cycle after reset;
- o_commit, o_cfg_err, o_lock and o_lock_lost all 0.
REQ-017 Reset during PEND SHALL discard the shadow configuration. Outputs SHALL revert to the defaults.

Configuration
REQ-018 With macro LTE_ANTSW_FRAME_LOCK_EN defined:
- the lock FSM is built;
- commit is permitted only on a head while o_lock=1.
REQ-019 Without LTE_ANTSW_FRAME_LOCK_EN:
- the lock FSM and counter are omitted;
- commit is permitted on any frame head;
- o_lock is tied to 1 and o_lock_lost to 0.

Structure
REQ-020 A shared package SHALL hold:
- config and lock FSM state enums;
- the mod_sel encoding constants;
- the default antenna map 32'h76543210;
- the default FRAME_LEN.
REQ-021 The lock FSM plus period counter SHALL be one sub-module, lte_up_dfe_framhd_lock, instantiated only under LTE_ANTSW_FRAME_LOCK_EN.

Verification
REQ-022 Reset then idle → o_ant_pos=32'h76543210, o_mod_sel=3, o_cfg_rdy=1, o_lock=0.
REQ-023 Macro on; heads every 4915200 cycles → o_lock rises at the 4th head. Then write 32'h01234567, mode 1 → o_commit at the next head; outputs change on that same edge.
REQ-024 Write 32'h00234567 (duplicate 0) → o_cfg_err pulse; FSM returns to IDLE; outputs unchanged.
REQ-025 Locked; one head arrives at period 4915197 → o_lock_lost pulse, o_lock=0; a PEND config is held until relock.
REQ-026 Locked; heads stop → o_lock falls when the counter reaches 4915202.
REQ-027 Macro off; PEND config and a single head → commit on that head, o_lock=1 throughout.

Source files
------------

// File: rtl/lte_up_dfe_antsw_cfg_sched_pkg.sv
// Shared types and constants for the antenna-switch configuration scheduler.
// Holds FSM encodings, bandwidth codes, reset antenna map and the config legality check.
package lte_up_dfe_antsw_cfg_sched_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_CHECK = 2'd1,
    CFG_PEND  = 2'd2,
    CFG_APPLY = 2'd3
  } cfg_state_e;

  typedef enum logic [1:0] {
    LK_UNLOCK = 2'd0,
    LK_SEARCH = 2'd1,
    LK_LOCK   = 2'd2
  } lock_state_e;

  localparam logic [1:0]  MOD_5M  = 2'd0;
  localparam logic [1:0]  MOD_10M = 2'd1;
  localparam logic [1:0]  MOD_15M = 2'd2;
  localparam logic [1:0]  MOD_20M = 2'd3;

  localparam logic [31:0] ANT_POS_DFLT   = 32'h7654_3210;
  localparam int          FRAME_LEN_DFLT = 4915200;
  localparam int          PCNT_W         = 23;

  // Legal map: every nibble has bit 3 clear and the 3-bit fields cover 0..7 exactly once.
  function automatic logic cfg_valid(input logic [31:0] ant);
    logic [7:0] seen;
    logic       ok;
    seen = '0;
    ok   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ok = ok & ~ant[4*i+3];
      seen[ant[4*i +: 3]] = 1'b1;
    end
    return ok && (seen == 8'hFF);
  endfunction

endpackage

// File: rtl/lte_up_dfe_antsw_cfg_sched_if.sv
// Configuration handshake, frame strobes and committed-map outputs of the scheduler.
// master drives config and strobes; slave is the scheduler itself.
interface lte_up_dfe_antsw_cfg_sched_if;
  logic        i_cfg_vld;
  logic [31:0] i_cfg_ant_pos;
  logic [1:0]  i_cfg_mod_sel;
  logic        o_cfg_rdy;
  logic        i_fram;
  logic        i_xant;
  logic [31:0] o_ant_pos;
  logic [1:0]  o_mod_sel;
  logic        o_commit;
  logic        o_cfg_err;
  logic        o_lock;
  logic        o_lock_lost;

  modport master (
    output i_cfg_vld, i_cfg_ant_pos, i_cfg_mod_sel, i_fram, i_xant,
    input  o_cfg_rdy, o_ant_pos, o_mod_sel, o_commit, o_cfg_err, o_lock, o_lock_lost
  );

  modport slave (
    input  i_cfg_vld, i_cfg_ant_pos, i_cfg_mod_sel, i_fram, i_xant,
    output o_cfg_rdy, o_ant_pos, o_mod_sel, o_commit, o_cfg_err, o_lock, o_lock_lost
  );
endinterface

// File: rtl/lte_up_dfe_framhd_lock.sv
// Frame-head period tracker: 23-bit period counter plus UNLOCK/SEARCH/LOCK FSM.
// Lock/lock_lost are registered; a head is judged against the state before its own edge.
module lte_up_dfe_framhd_lock
  import lte_up_dfe_antsw_cfg_sched_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DFLT,
  parameter int FRAME_TOL = 2,
  parameter int LOCK_CNT  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic head,
  output logic lock,
  output logic lock_lost
);

  localparam logic [PCNT_W-1:0] LIMIT  = PCNT_W'(FRAME_LEN + FRAME_TOL);
  localparam logic [PCNT_W-1:0] LO_PER = PCNT_W'(FRAME_LEN - FRAME_TOL);
  localparam int                GW     = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]     GOOD_LAST = GW'(LOCK_CNT - 1);

  lock_state_e       state_q, state_d;
  logic [PCNT_W-1:0] cnt_q, period;
  logic [GW-1:0]     good_q, good_d;
  logic              lost_q, in_tol, timeout;

  assign period  = cnt_q + PCNT_W'(1);
  assign in_tol  = (period >= LO_PER) && (period <= LIMIT);
  // Next edge would push the counter to its ceiling with no head in sight.
  assign timeout = !head && (cnt_q == LIMIT - PCNT_W'(1));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      LK_UNLOCK: begin
        if (head) begin
          state_d = LK_SEARCH;
          good_d  = '0;
        end
      end
      LK_SEARCH: begin
        if (head) begin
          if (!in_tol)                 good_d  = '0;
          else if (good_q == GOOD_LAST) state_d = LK_LOCK;
          else                         good_d  = good_q + GW'(1);
        end else if (timeout) begin
          state_d = LK_UNLOCK;
        end
      end
      LK_LOCK: begin
        if ((head && !in_tol) || timeout) state_d = LK_UNLOCK;
      end
      default: state_d = LK_UNLOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LK_UNLOCK;
      good_q  <= '0;
      cnt_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      lost_q  <= (state_q == LK_LOCK) && (state_d != LK_LOCK);
      if (head)               cnt_q <= '0;
      else if (cnt_q != LIMIT) cnt_q <= cnt_q + PCNT_W'(1);
    end
  end

  assign lock      = (state_q == LK_LOCK);
  assign lock_lost = lost_q;

endmodule

// File: rtl/lte_up_dfe_antsw_cfg_sched.sv
// Antenna-map/bandwidth config scheduler: validates a config, then applies it on a frame head.
// Accepts one config at a time (ready only in IDLE); LTE_ANTSW_FRAME_LOCK_EN gates commits on frame lock.
module lte_up_dfe_antsw_cfg_sched
  import lte_up_dfe_antsw_cfg_sched_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DFLT,
  parameter int FRAME_TOL = 2,
  parameter int LOCK_CNT  = 3
) (
  input  logic                          sys_clk_491p52,
  input  logic                          sys_rst_491p52,
  lte_up_dfe_antsw_cfg_sched_if.slave   bus
);

  cfg_state_e  cfg_q, cfg_d;
  logic        head, permit, lock, lock_lost;
  logic        rdy_en_q, cfg_ok_q, cfg_rdy, accept;
  logic [31:0] shd_ant_q, ant_q;
  logic [1:0]  shd_mod_q, mod_q;

  assign head    = bus.i_fram & bus.i_xant;
  assign cfg_rdy = (cfg_q == CFG_IDLE) && rdy_en_q;
  assign accept  = bus.i_cfg_vld && cfg_rdy;

`ifdef LTE_ANTSW_FRAME_LOCK_EN
  lte_up_dfe_framhd_lock #(
    .FRAME_LEN (FRAME_LEN),
    .FRAME_TOL (FRAME_TOL),
    .LOCK_CNT  (LOCK_CNT)
  ) u_lock (
    .clk       (sys_clk_491p52),
    .rst_n     (sys_rst_491p52),
    .head      (head),
    .lock      (lock),
    .lock_lost (lock_lost)
  );
  // Registered lock is the pre-edge state, so a head that completes lock cannot also commit.
  assign permit = head && lock;
`else
  logic unused_timing_params;
  assign unused_timing_params = ^{32'(FRAME_LEN), 32'(FRAME_TOL), 32'(LOCK_CNT)};
  assign lock      = 1'b1;
  assign lock_lost = 1'b0;
  assign permit    = head;
`endif

  always_comb begin
    cfg_d = cfg_q;
    case (cfg_q)
      CFG_IDLE:  if (accept) cfg_d = CFG_CHECK;
      CFG_CHECK: cfg_d = cfg_ok_q ? CFG_PEND : CFG_IDLE;
      CFG_PEND:  if (permit) cfg_d = CFG_APPLY;
      CFG_APPLY: cfg_d = CFG_IDLE;
      default:   cfg_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_491p52) begin
    if (!sys_rst_491p52) begin
      cfg_q     <= CFG_IDLE;
      rdy_en_q  <= 1'b0;
      cfg_ok_q  <= 1'b0;
      shd_ant_q <= ANT_POS_DFLT;
      shd_mod_q <= MOD_20M;
      ant_q     <= ANT_POS_DFLT;
      mod_q     <= MOD_20M;
    end else begin
      cfg_q    <= cfg_d;
      rdy_en_q <= 1'b1;
      if (accept) begin
        shd_ant_q <= bus.i_cfg_ant_pos;
        shd_mod_q <= bus.i_cfg_mod_sel;
        cfg_ok_q  <= cfg_valid(bus.i_cfg_ant_pos);
      end
      if ((cfg_q == CFG_PEND) && (cfg_d == CFG_APPLY)) begin
        ant_q <= shd_ant_q;
        mod_q <= shd_mod_q;
      end
    end
  end

  assign bus.o_cfg_rdy   = cfg_rdy;
  assign bus.o_ant_pos   = ant_q;
  assign bus.o_mod_sel   = mod_q;
  assign bus.o_commit    = (cfg_q == CFG_APPLY);
  assign bus.o_cfg_err   = (cfg_q == CFG_CHECK) && !cfg_ok_q;
  assign bus.o_lock      = lock;
  assign bus.o_lock_lost = lock_lost;

endmodule

// File: tb/tb_lte_up_dfe_antsw_cfg_sched.sv
// Directed bench for the antenna-switch config scheduler with a shortened frame (20 cycles, tol 2).
// Covers both builds; the lock-dependent sequence is selected by LTE_ANTSW_FRAME_LOCK_EN.
module tb_lte_up_dfe_antsw_cfg_sched;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   since_head = 0;

  always #5 clk = ~clk;

  lte_up_dfe_antsw_cfg_sched_if bus ();

  lte_up_dfe_antsw_cfg_sched #(
    .FRAME_LEN (20),
    .FRAME_TOL (2),
    .LOCK_CNT  (3)
  ) dut (
    .sys_clk_491p52 (clk),
    .sys_rst_491p52 (rst_n),
    .bus            (bus)
  );

`ifdef LTE_ANTSW_FRAME_LOCK_EN
  localparam logic LOCK_IDLE = 1'b0;
`else
  localparam logic LOCK_IDLE = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since_head++;
  endtask

  task automatic head();
    bus.i_fram = 1'b1;
    bus.i_xant = 1'b1;
    tick();
    bus.i_fram = 1'b0;
    bus.i_xant = 1'b0;
    since_head = 0;
  endtask

  // Issue a head so that it lands p cycles after the previous one.
  task automatic head_at(input int p);
    while (since_head < p - 1) tick();
    head();
  endtask

  task automatic cfg_write(input logic [31:0] ant, input logic [1:0] mode);
    bus.i_cfg_vld     = 1'b1;
    bus.i_cfg_ant_pos = ant;
    bus.i_cfg_mod_sel = mode;
    tick();
    bus.i_cfg_vld = 1'b0;
  endtask

  initial begin
    bus.i_cfg_vld     = 1'b0;
    bus.i_cfg_ant_pos = '0;
    bus.i_cfg_mod_sel = '0;
    bus.i_fram        = 1'b0;
    bus.i_xant        = 1'b0;

    repeat (3) tick();
    chk("rst_rdy",      32'(bus.o_cfg_rdy),   32'd0);
    chk("rst_commit",   32'(bus.o_commit),    32'd0);
    chk("rst_err",      32'(bus.o_cfg_err),   32'd0);
    chk("rst_lost",     32'(bus.o_lock_lost), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy",  32'(bus.o_cfg_rdy), 32'd1);
    chk("idle_ant",  bus.o_ant_pos,      32'h7654_3210);
    chk("idle_mod",  32'(bus.o_mod_sel), 32'd3);
    chk("idle_lock", 32'(bus.o_lock),    32'(LOCK_IDLE));

`ifdef LTE_ANTSW_FRAME_LOCK_EN
    head();
    head_at(20);
    head_at(20);
    chk("search_lock", 32'(bus.o_lock), 32'd0);
    head_at(20);
    chk("lock_4th_head", 32'(bus.o_lock), 32'd1);

    cfg_write(32'h0123_4567, 2'd1);
    tick();
    chk("pend_no_commit", 32'(bus.o_commit), 32'd0);
    head_at(20);
    chk("lk_commit",     32'(bus.o_commit), 32'd1);
    chk("lk_commit_ant", bus.o_ant_pos,     32'h0123_4567);
    chk("lk_commit_mod", 32'(bus.o_mod_sel), 32'd1);
    tick();
    chk("lk_apply_idle", 32'(bus.o_commit), 32'd0);

    cfg_write(32'h0023_4567, 2'd2);
    chk("lk_dup_err", 32'(bus.o_cfg_err), 32'd1);
    tick();
    chk("lk_dup_err_end", 32'(bus.o_cfg_err), 32'd0);
    chk("lk_dup_rdy",     32'(bus.o_cfg_rdy), 32'd1);
    chk("lk_dup_ant",     bus.o_ant_pos,      32'h0123_4567);

    head_at(17);
    chk("short_lost",   32'(bus.o_lock_lost), 32'd1);
    chk("short_unlock", 32'(bus.o_lock),      32'd0);
    tick();
    chk("lost_pulse_end", 32'(bus.o_lock_lost), 32'd0);
    cfg_write(32'h1032_5476, 2'd2);
    tick();
    head_at(20);
    chk("relock1_commit", 32'(bus.o_commit), 32'd0);
    chk("held_ant",       bus.o_ant_pos,     32'h0123_4567);
    head_at(20);
    head_at(20);
    head_at(20);
    chk("relock_lock",        32'(bus.o_lock),   32'd1);
    chk("relock_edge_commit", 32'(bus.o_commit), 32'd0);
    head_at(20);
    chk("held_commit",     32'(bus.o_commit),  32'd1);
    chk("held_commit_ant", bus.o_ant_pos,      32'h1032_5476);
    chk("held_commit_mod", 32'(bus.o_mod_sel), 32'd2);

    head_at(22);
    chk("tol_hi_lock", 32'(bus.o_lock), 32'd1);
    head_at(18);
    chk("tol_lo_lock", 32'(bus.o_lock), 32'd1);
    while (since_head < 21) tick();
    chk("timeout_pre_lock", 32'(bus.o_lock), 32'd1);
    tick();
    chk("timeout_lock", 32'(bus.o_lock),      32'd0);
    chk("timeout_lost", 32'(bus.o_lock_lost), 32'd1);
`else
    cfg_write(32'h0123_4567, 2'd1);
    chk("check_rdy", 32'(bus.o_cfg_rdy), 32'd0);
    tick();
    chk("pend_no_commit", 32'(bus.o_commit), 32'd0);
    bus.i_fram = 1'b1;
    tick();
    bus.i_fram = 1'b0;
    chk("fram_only_commit", 32'(bus.o_commit), 32'd0);
    chk("fram_only_ant",    bus.o_ant_pos,     32'h7654_3210);
    bus.i_xant = 1'b1;
    tick();
    bus.i_xant = 1'b0;
    chk("xant_only_commit", 32'(bus.o_commit), 32'd0);
    head();
    chk("head_commit", 32'(bus.o_commit),  32'd1);
    chk("head_ant",    bus.o_ant_pos,      32'h0123_4567);
    chk("head_mod",    32'(bus.o_mod_sel), 32'd1);
    chk("head_lock",   32'(bus.o_lock),    32'd1);
    tick();
    chk("apply_end_commit", 32'(bus.o_commit),  32'd0);
    chk("apply_end_rdy",    32'(bus.o_cfg_rdy), 32'd1);

    cfg_write(32'h0023_4567, 2'd2);
    chk("dup_err", 32'(bus.o_cfg_err), 32'd1);
    tick();
    chk("dup_err_end", 32'(bus.o_cfg_err), 32'd0);
    chk("dup_rdy",     32'(bus.o_cfg_rdy), 32'd1);
    chk("dup_ant",     bus.o_ant_pos,      32'h0123_4567);
    chk("dup_mod",     32'(bus.o_mod_sel), 32'd1);

    cfg_write(32'h8123_4567, 2'd0);
    chk("bit3_err", 32'(bus.o_cfg_err), 32'd1);
    tick();
    head();
    chk("bit3_no_commit", 32'(bus.o_commit), 32'd0);
    chk("bit3_ant",       bus.o_ant_pos,     32'h0123_4567);

    cfg_write(32'h1032_5476, 2'd2);
    repeat (5) tick();
    chk("pend_stable_ant", bus.o_ant_pos,      32'h0123_4567);
    chk("pend_stable_mod", 32'(bus.o_mod_sel), 32'd1);
    head();
    chk("second_commit", 32'(bus.o_commit),  32'd1);
    chk("second_ant",    bus.o_ant_pos,      32'h1032_5476);
    chk("second_mod",    32'(bus.o_mod_sel), 32'd2);
    tick();

    cfg_write(32'h4567_0123, 2'd0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("pend_rst_ant", bus.o_ant_pos,      32'h7654_3210);
    chk("pend_rst_mod", 32'(bus.o_mod_sel), 32'd3);
    chk("pend_rst_rdy", 32'(bus.o_cfg_rdy), 32'd0);
    rst_n = 1'b1;
    tick();
    head();
    chk("pend_rst_no_commit", 32'(bus.o_commit),  32'd0);
    chk("pend_rst_keep_ant",  bus.o_ant_pos,      32'h7654_3210);
    chk("pend_rst_rdy_back",  32'(bus.o_cfg_rdy), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
